pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline; generalises the current load-use hazard unit.
//  Adds: configurable load-to-use latency (scoreboard countdown), data-memory ready/valid wait-state freeze,
//  branch-flush sequencing with a parametrised number of flushed stages, and a memory-timeout error flag.
//  Sits beside the forwarding unit; drives PC write enable, IF/ID write enable, ID/EX bubble and per-stage flushes.
// PARAMETERS
//  REG_NUM_BITWIDTH  5   register index width
//  LOAD_LATENCY      1   cycles after load leaves EX before its data is forwardable (>=1; 1 = classic 1-bubble)
//  FLUSH_STAGES      3   younger pipeline registers cleared on taken branch (bit0=IF/ID, bit1=ID/EX, bit2=EX/MEM)
//  MEM_TIMEOUT       255 max consecutive not-ready cycles before mem_err (>=1)
// PORTS
//  clk           in   1                   clock, rising edge
//  rst           in   1                   synchronous reset, active-high
//  id_Rs1        in   REG_NUM_BITWIDTH    source reg 1 of instruction in ID
//  id_Rs2        in   REG_NUM_BITWIDTH    source reg 2 of instruction in ID
//  id_useRs1     in   1                   ID instruction reads Rs1
//  id_useRs2     in   1                   ID instruction reads Rs2
//  ex_memRead    in   1                   instruction in EX is a load
//  ex_Rd         in   REG_NUM_BITWIDTH    destination of instruction in EX
//  branch_taken  in   1                   taken branch resolved in EX/MEM (1-cycle pulse)
//  mem_req       in   1                   data memory access in MEM this cycle
//  mem_ready     in   1                   data memory completes access this cycle
//  pc_write      out  1                   PC register enable
//  if_id_write   out  1                   IF/ID register enable
//  id_ex_bubble  out  1                   insert NOP into ID/EX
//  freeze        out  1                   hold ID/EX, EX/MEM, MEM/WB (memory wait)
//  flush         out  FLUSH_STAGES        per-register synchronous clear
//  mem_err       out  1                   sticky: memory timeout seen
// BEHAVIOUR
//  - Reset: state=RUN, pend_cnt=0, held_branch=0, wait_cnt=0, mem_err=0. While rst=1 outputs:
//    pc_write=0, if_id_write=0, id_ex_bubble=0, freeze=0, flush=all ones.
//  - States: RUN, MEM_WAIT, FLUSH. Combinational outputs from state + inputs; registers update on clk.
//  - Priority per cycle: rst > memory wait > branch flush > load-use stall > run.
//  - MEM_WAIT entry: mem_req & !mem_ready -> freeze=1, pc_write=0, if_id_write=0, flush=0, same cycle.
//    Stays while mem_ready=0; wait_cnt increments, saturating at MEM_TIMEOUT; reaching MEM_TIMEOUT sets mem_err
//    (sticky until rst; freeze continues). mem_ready=1 -> wait_cnt=0, outputs as RUN that cycle.
//  - branch_taken during freeze is latched into held_branch; applied in first unfrozen cycle (state FLUSH).
//  - Branch (branch_taken, or held_branch when unfrozen): flush=all ones for exactly 1 cycle, pc_write=1
//    (target load), id_ex_bubble=0; pend_cnt cleared (pending load is older, already past hazard window),
//    held_branch cleared. FLUSH returns to RUN next cycle.
//  - Load-use: hit = ex_memRead & ex_Rd!=0 & ((id_useRs1 & id_Rs1==ex_Rd) | (id_useRs2 & id_Rs2==ex_Rd)).
//    Pending hit = pend_cnt!=0 & same comparison against pend_rd. Either -> pc_write=0, if_id_write=0, id_ex_bubble=1.
//  - Scoreboard: when a load leaves EX (ex_memRead, not frozen, not flushed) pend_rd<=ex_Rd, pend_cnt<=LOAD_LATENCY-1.
//    pend_cnt decrements by 1 per unfrozen cycle, never below 0; frozen cycles hold it.
//    LOAD_LATENCY=1 -> pend_cnt stays 0: exactly one bubble per load-use pair.
//  - Register x0 never creates a hazard. Simultaneous new load and pending entry: new load overwrites entry.
//  - Run: pc_write=1, if_id_write=1, id_ex_bubble=0, freeze=0, flush=0.
//  - rst mid-MEM_WAIT or mid-stall: all state cleared next edge; held_branch discarded.
// TESTING
//  1. LOAD_LATENCY=1: lw x5 in EX, add x6,x5,x1 in ID -> 1 cycle bubble=1,pc_write=0; next cycle run.
//  2. LOAD_LATENCY=3: same pair -> 3 consecutive bubble cycles; ex_Rd=x0 load -> 0 bubbles.
//  3. mem_req=1, mem_ready=0 for 4 cycles -> freeze=1 for 4 cycles, pend_cnt held, mem_err=0.
//  4. branch_taken pulse in 2nd frozen cycle -> no flush while frozen; flush=3'b111 one cycle after mem_ready.
//  5. MEM_TIMEOUT=8, mem_ready held 0 -> mem_err=1 from 8th wait cycle, stays 1 until rst.
//  6. rst asserted during load-use stall -> flush=all ones, pc_write=0; after release run, no residual bubble.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use scoreboard,
// data-memory wait freeze, branch flush sequencing and memory timeout flag.
module pipe_hazard_ctrl #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int LOAD_LATENCY     = 1,
  parameter int FLUSH_STAGES     = 3,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
  input  logic                        id_useRs1,
  input  logic                        id_useRs2,
  input  logic                        ex_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_Rd,
  input  logic                        branch_taken,
  input  logic                        mem_req,
  input  logic                        mem_ready,
  output logic                        pc_write,
  output logic                        if_id_write,
  output logic                        id_ex_bubble,
  output logic                        freeze,
  output logic [FLUSH_STAGES-1:0]     flush,
  output logic                        mem_err
);

  localparam int PW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               pend_cnt_q, pend_cnt_d;
  logic [REG_NUM_BITWIDTH-1:0] pend_rd_q, pend_rd_d;
  logic                        held_branch_q, held_branch_d;
  logic [WW-1:0]               wait_cnt_q, wait_cnt_d;
  logic                        mem_err_q, mem_err_d;

  logic mem_stall;
  logic branch_act;
  logic ex_hit;
  logic pend_hit;
  logic timeout_now;

  // Once in MEM_WAIT the freeze holds until the memory answers, even if mem_req drops.
  always_comb begin
    mem_stall   = (state_q == ST_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
    branch_act  = !mem_stall && (branch_taken || (state_q == ST_FLUSH));
    ex_hit      = ex_memRead && (ex_Rd != '0) &&
                  ((id_useRs1 && (id_Rs1 == ex_Rd)) || (id_useRs2 && (id_Rs2 == ex_Rd)));
    pend_hit    = (pend_cnt_q != '0) && (pend_rd_q != '0) &&
                  ((id_useRs1 && (id_Rs1 == pend_rd_q)) || (id_useRs2 && (id_Rs2 == pend_rd_q)));
    timeout_now = mem_stall && (wait_cnt_q >= WW'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    flush        = '0;
    mem_err      = !rst && (mem_err_q || timeout_now);
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush       = '1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      freeze      = 1'b1;
    end else if (branch_act) begin
      flush       = '1;
    end else if (ex_hit || pend_hit) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // A branch seen while frozen is replayed from FLUSH in the cycle after release.
  always_comb begin
    state_d       = ST_RUN;
    pend_cnt_d    = pend_cnt_q;
    pend_rd_d     = pend_rd_q;
    held_branch_d = held_branch_q;
    wait_cnt_d    = '0;
    mem_err_d     = mem_err_q || timeout_now;
    if (mem_stall) begin
      state_d       = ST_MEM_WAIT;
      held_branch_d = held_branch_q || branch_taken;
      wait_cnt_d    = (wait_cnt_q < WW'(MEM_TIMEOUT)) ? wait_cnt_q + WW'(1) : wait_cnt_q;
    end else if (branch_act) begin
      held_branch_d = 1'b0;
      pend_cnt_d    = '0;
    end else begin
      if ((state_q == ST_MEM_WAIT) && held_branch_q) begin
        state_d = ST_FLUSH;
      end
      if (ex_memRead) begin
        pend_rd_d  = ex_Rd;
        pend_cnt_d = PW'(LOAD_LATENCY - 1);
      end else if (pend_cnt_q != '0) begin
        pend_cnt_d = pend_cnt_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pend_cnt_q    <= '0;
      pend_rd_q     <= '0;
      held_branch_q <= 1'b0;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_cnt_q    <= pend_cnt_d;
      pend_rd_q     <= pend_rd_d;
      held_branch_q <= held_branch_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: dut 0 uses LOAD_LATENCY=1, dut 1 uses
// LOAD_LATENCY=3 with MEM_TIMEOUT=8; both see identical inputs.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [4:0] id_Rs1 = '0, id_Rs2 = '0, ex_Rd = '0;
  logic       id_useRs1 = 1'b0, id_useRs2 = 1'b0, ex_memRead = 1'b0;
  logic       branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic       a_pc, a_ifid, a_bub, a_frz, a_err;
  logic [2:0] a_fl;
  logic       b_pc, b_ifid, b_bub, b_frz, b_err;
  logic [2:0] b_fl;

  pipe_hazard_ctrl #(.REG_NUM_BITWIDTH(5), .LOAD_LATENCY(1), .FLUSH_STAGES(3), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_useRs1(id_useRs1),
    .id_useRs2(id_useRs2), .ex_memRead(ex_memRead), .ex_Rd(ex_Rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(a_pc), .if_id_write(a_ifid),
    .id_ex_bubble(a_bub), .freeze(a_frz), .flush(a_fl), .mem_err(a_err));

  pipe_hazard_ctrl #(.REG_NUM_BITWIDTH(5), .LOAD_LATENCY(3), .FLUSH_STAGES(3), .MEM_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_useRs1(id_useRs1),
    .id_useRs2(id_useRs2), .ex_memRead(ex_memRead), .ex_Rd(ex_Rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(b_pc), .if_id_write(b_ifid),
    .id_ex_bubble(b_bub), .freeze(b_frz), .flush(b_fl), .mem_err(b_err));

  // Output patterns {pc_write, if_id_write, id_ex_bubble, freeze, flush[2:0]}
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_STALL = 7'b0010000;
  localparam logic [6:0] O_FRZ   = 7'b0001000;
  localparam logic [6:0] O_FLS   = 7'b1100111;
  localparam logic [6:0] O_RST   = 7'b0000111;
  localparam int         ERR_X   = 2;

  typedef struct {
    int         dut;
    logic [6:0] outs;
    int         err;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  task automatic applyStimulus(input logic r, input logic ld, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic bt, input logic mq, input logic my);
    @(posedge clk);
    #1;
    rst = r; ex_memRead = ld; ex_Rd = rd;
    id_Rs1 = rs1; id_useRs1 = u1; id_Rs2 = rs2; id_useRs2 = u2;
    branch_taken = bt; mem_req = mq; mem_ready = my;
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic bt, input logic mq, input logic my,
                     input logic [6:0] aOut, input int aErr,
                     input logic [6:0] bOut, input int bErr, input string name);
    exp_t e;
    applyStimulus(r, ld, rd, rs1, u1, rs2, u2, bt, mq, my);
    e.dut = 0; e.outs = aOut; e.err = aErr; e.name = name;
    expQ.push_back(e);
    e.dut = 1; e.outs = bOut; e.err = bErr;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] act;
    logic       actErr;
    logic       expErr;
    if (e.dut == 0) begin
      act = {a_pc, a_ifid, a_bub, a_frz, a_fl};
      actErr = a_err;
    end else begin
      act = {b_pc, b_ifid, b_bub, b_frz, b_fl};
      actErr = b_err;
    end
    checkCount++;
    if (act === e.outs) passCount++;
    else $display("[TB] FAIL %s dut%0d {pc,ifid,bub,frz,flush}: got %b expected %b",
                  e.name, e.dut, act, e.outs);
    if (e.err != ERR_X) begin
      expErr = (e.err == 1);
      checkCount++;
      if (actErr === expErr) passCount++;
      else $display("[TB] FAIL %s dut%0d mem_err: got %b expected %b", e.name, e.dut, actErr, expErr);
    end
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    $display("[TB] start");
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "reset");
    // load-use, latency 1 vs 3
    cyc(0,1,5,5,1,1,1,0,0,0, O_STALL,0, O_STALL,0, "lu_ex_hit");
    cyc(0,0,0,5,1,1,1,0,0,0, O_RUN,0,   O_STALL,0, "lu_lat_c1");
    cyc(0,0,0,5,1,1,1,0,0,0, O_RUN,0,   O_STALL,0, "lu_lat_c2");
    cyc(0,0,0,5,1,1,1,0,0,0, O_RUN,0,   O_RUN,0,   "lu_lat_c3");
    cyc(0,1,7,3,1,7,1,0,0,0, O_STALL,0, O_STALL,0, "lu_rs2_hit");
    cyc(0,1,9,7,1,9,0,0,0,0, O_RUN,0,   O_STALL,0, "lu_pend_hit");
    cyc(0,0,0,7,1,0,0,0,0,0, O_RUN,0,   O_RUN,0,   "lu_overwrite");
    cyc(0,0,0,0,0,9,1,0,0,0, O_RUN,0,   O_STALL,0, "lu_new_entry");
    cyc(0,0,0,0,0,9,1,0,0,0, O_RUN,0,   O_RUN,0,   "lu_new_done");
    cyc(0,1,5,5,0,0,1,0,0,0, O_RUN,0,   O_RUN,0,   "lu_use_gate");
    cyc(0,0,0,5,1,0,0,0,0,0, O_RUN,0,   O_STALL,0, "lu_pend_after_gate");
    // x0 destination never hazards
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "reset_x0");
    cyc(0,1,0,0,1,0,1,0,0,0, O_RUN,0, O_RUN,0, "x0_ex");
    cyc(0,0,0,0,1,0,1,0,0,0, O_RUN,0, O_RUN,0, "x0_pend");
    // memory wait holds the pending-load countdown
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "reset_mw");
    cyc(0,1,5,2,1,0,0,0,0,0, O_RUN,0, O_RUN,0, "mw_load");
    for (int k = 0; k < 4; k++)
      cyc(0,0,0,5,1,0,0,0,1,0, O_FRZ,0, O_FRZ,0, "mw_freeze");
    cyc(0,0,0,5,1,0,0,0,1,1, O_RUN,0, O_STALL,0, "mw_release");
    cyc(0,0,0,5,1,0,0,0,0,0, O_RUN,0, O_STALL,0, "mw_pend_c2");
    cyc(0,0,0,5,1,0,0,0,0,0, O_RUN,0, O_RUN,0,   "mw_pend_done");
    // branch handling
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "reset_br");
    cyc(0,0,0,0,0,0,0,0,1,0, O_FRZ,0, O_FRZ,0, "br_frz1");
    cyc(0,0,0,0,0,0,0,1,1,0, O_FRZ,0, O_FRZ,0, "br_in_freeze");
    cyc(0,0,0,0,0,0,0,0,1,0, O_FRZ,0, O_FRZ,0, "br_frz3");
    cyc(0,0,0,0,0,0,0,0,1,1, O_RUN,0, O_RUN,0, "br_release");
    cyc(0,0,0,0,0,0,0,0,0,0, O_FLS,0, O_FLS,0, "br_held_flush");
    cyc(0,0,0,0,0,0,0,0,0,0, O_RUN,0, O_RUN,0, "br_after");
    cyc(0,1,5,5,1,0,0,1,0,0, O_FLS,0, O_FLS,0, "br_over_lu");
    cyc(0,0,0,5,1,0,0,0,0,0, O_RUN,0, O_RUN,0, "br_pend_clr");
    cyc(0,0,0,0,0,0,0,1,1,0, O_FRZ,0, O_FRZ,0, "br_mem_prio");
    cyc(0,0,0,0,0,0,0,0,1,1, O_RUN,0, O_RUN,0, "br_mem_rel");
    cyc(0,0,0,0,0,0,0,0,0,0, O_FLS,0, O_FLS,0, "br_held2");
    cyc(0,0,0,0,0,0,0,0,0,0, O_RUN,0, O_RUN,0, "br_after2");
    // memory timeout (dut 1 has MEM_TIMEOUT=8)
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "reset_to");
    for (int k = 1; k <= 10; k++)
      cyc(0,0,0,0,0,0,0,0,1,0, O_FRZ,0, O_FRZ,((k >= 8) ? 1 : 0), "timeout_wait");
    cyc(0,0,0,0,0,0,0,0,1,1, O_RUN,0, O_RUN,1, "timeout_release");
    cyc(0,0,0,0,0,0,0,0,0,0, O_RUN,0, O_RUN,1, "err_sticky");
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "err_reset");
    cyc(0,0,0,0,0,0,0,0,0,0, O_RUN,0, O_RUN,0, "err_cleared");
    // reset in the middle of a stall and of a memory wait
    cyc(0,1,5,5,1,0,0,0,0,0, O_STALL,0, O_STALL,0, "rst_lu_stall");
    cyc(1,0,0,5,1,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "rst_mid_stall");
    cyc(0,0,0,5,1,0,0,0,0,0, O_RUN,0, O_RUN,0, "rst_no_residual");
    cyc(0,0,0,0,0,0,0,1,1,0, O_FRZ,0, O_FRZ,0, "rst_frz_branch");
    cyc(1,0,0,0,0,0,0,0,0,0, O_RST,ERR_X, O_RST,ERR_X, "rst_mid_wait");
    cyc(0,0,0,0,0,0,0,0,0,0, O_RUN,0, O_RUN,0, "rst_branch_drop");
    cyc(0,0,0,0,0,0,0,0,0,0, O_RUN,0, O_RUN,0, "rst_idle");

    @(negedge clk);
    #1;
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
